// File: rtl/registrador_controle.sv
// Control FSM for a 16-bit universal shift register: parallel load, then n_shifts serial shifts.
// Optional 16-bit circular rotate (forward direction only) enabled by defining REGISTRADOR_ROTATE_EN.
module registrador_controle (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic       rot,
    input  logic [4:0] n_shifts,
    input  logic       serial_in,
    input  logic       saida_ultimoflip,
    input  logic       saida_primeiroflip,
    output logic       ch0,
    output logic       ch1,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [4:0] cnt
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] MAX_SHIFTS = CNT_W'(16);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] n_clamped;

    assign n_clamped = (n_shifts > MAX_SHIFTS) ? MAX_SHIFTS : n_shifts;
    assign ch1       = mode_q[1];
    assign ch0       = mode_q[0];

`ifdef REGISTRADOR_ROTATE_EN
    logic rot_q;
`endif

    // Sequencer; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            cnt       <= '0;
            mode_q    <= MODE_HOLD;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_valid <= 1'b0;
`ifdef REGISTRADOR_ROTATE_EN
            rot_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mode_q    <= MODE_HOLD;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    bit_valid <= 1'b0;
                    if (start) begin
                        state  <= LOAD;
                        dir_q  <= dir;
                        cnt    <= n_clamped;
                        mode_q <= MODE_LOAD;
                        busy   <= 1'b1;
`ifdef REGISTRADOR_ROTATE_EN
                        rot_q  <= rot;
`endif
                    end
                end
                LOAD: begin
                    if (cnt != '0) begin
                        state     <= SHIFT;
                        mode_q    <= dir_q ? MODE_REV : MODE_FWD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        bit_valid <= 1'b1;
                    end else begin
                        state     <= FIN;
                        mode_q    <= MODE_HOLD;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        bit_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    // Last shift: leave with cnt already at zero
                    if (cnt == CNT_W'(1)) begin
                        state     <= FIN;
                        mode_q    <= MODE_HOLD;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        bit_valid <= 1'b0;
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    mode_q    <= MODE_HOLD;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    bit_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    mode_q    <= MODE_HOLD;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    bit_valid <= 1'b0;
                end
            endcase
        end
    end

    // Bit leaving the register: q15 on forward shift, q0 on reverse
    assign bit_out = (state == SHIFT) ? (dir_q ? saida_primeiroflip : saida_ultimoflip) : 1'b0;

`ifdef REGISTRADOR_ROTATE_EN
    assign d = (state == SHIFT && rot_q && !dir_q) ? saida_ultimoflip : serial_in;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign d          = serial_in;
`endif

endmodule

// File: tb/tb_registrador_controle.sv
// Scoreboard bench for registrador_controle with a behavioural 16-bit shift register
// closing the loop between ch1/ch0/d and saida_ultimoflip/saida_primeiroflip.
module tb_registrador_controle;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic       rot;
    logic [4:0] n_shifts;
    logic       serial_in;
    logic       saida_ultimoflip;
    logic       saida_primeiroflip;
    logic       ch0, ch1, d, busy, done, bit_out, bit_valid;
    logic [4:0] cnt;

    logic [15:0] sr = 16'h0000;
    logic [15:0] load_val;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] mode;
        logic       busy;
        logic       done;
        logic       bv;
        logic       bitv;
        logic       rotd;
        logic [4:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    registrador_controle dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .dir                (dir),
        .rot                (rot),
        .n_shifts           (n_shifts),
        .serial_in          (serial_in),
        .saida_ultimoflip   (saida_ultimoflip),
        .saida_primeiroflip (saida_primeiroflip),
        .ch0                (ch0),
        .ch1                (ch1),
        .d                  (d),
        .busy               (busy),
        .done               (done),
        .bit_out            (bit_out),
        .bit_valid          (bit_valid),
        .cnt                (cnt)
    );

    // The register being controlled
    always @(posedge clk) begin
        case ({ch1, ch0})
            2'b01:   sr <= {sr[14:0], d};
            2'b10:   sr <= {d, sr[15:1]};
            2'b11:   sr <= load_val;
            default: sr <= sr;
        endcase
    end

    assign saida_ultimoflip   = sr[15];
    assign saida_primeiroflip = sr[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] mode, input logic b, input logic dn, input logic bv,
                        input logic [4:0] c, input logic bitv, input logic rotd);
        exp_t e;
        e.mode = mode; e.busy = b; e.done = dn; e.bv = bv;
        e.cnt = c; e.bitv = bitv; e.rotd = rotd;
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        push(2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Expected LOAD, up to n SHIFT cycles (stopping after 'keep'), and FIN if not cut short
    task automatic push_op(input logic [4:0] n_raw, input logic dr, input logic rt,
                           input logic [15:0] word, input int keep);
        int   n;
        logic rotd;
        logic [15:0] w;
        n = (n_raw > 5'd16) ? 16 : int'(n_raw);
        w = word;
`ifdef REGISTRADOR_ROTATE_EN
        rotd = rt & ~dr;
`else
        rotd = 1'b0;
        if (rt) rotd = 1'b0;
`endif
        push(2'b11, 1'b1, 1'b0, 1'b0, 5'(n), 1'b0, 1'b0);
        for (int k = 0; k < n && k < keep; k++)
            push(dr ? 2'b10 : 2'b01, 1'b1, 1'b0, 1'b1, 5'(n - k),
                 dr ? w[4'(k)] : w[4'(15 - k)], rotd);
        if (keep >= n)
            push(2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        exp_t e;
        logic exp_d;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("mode",      32'({ch1, ch0}), 32'(e.mode));
            check("busy",      32'(busy),       32'(e.busy));
            check("done",      32'(done),       32'(e.done));
            check("bit_valid", 32'(bit_valid),  32'(e.bv));
            check("cnt",       32'(cnt),        32'(e.cnt));
            check("bit_out",   32'(bit_out),    32'(e.bitv));
            exp_d = e.rotd ? saida_ultimoflip : serial_in;
            check("d",         32'(d),          32'(exp_d));
        end
        serial_in = 1'($urandom);
    endtask

    task automatic run_op(input logic [4:0] n, input logic dr, input logic rt,
                          input logic [15:0] word, input logic hold);
        int n_eff;
        n_eff    = (n > 5'd16) ? 16 : int'(n);
        start    = 1'b1;
        dir      = dr;
        rot      = rt;
        n_shifts = n;
        load_val = word;
        push_op(n, dr, rt, word, 17);
        step();
        if (!hold) begin
            start    = 1'b0;
            dir      = ~dr;
            rot      = ~rt;
            n_shifts = 5'd3;
        end
        repeat (n_eff + 1) step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; rot = 1'b0;
        n_shifts = 5'd0; serial_in = 1'b0; load_val = 16'h0000;

        // Reset state
        push_idle(); step();
        rst = 1'b0;
        push_idle(); step();

        // Forward shift of 4, inputs scrambled after the start edge
        run_op(5'd4, 1'b0, 1'b0, 16'hA5C3, 1'b0);
        push_idle(); step();

        // Zero count goes LOAD -> FIN
        run_op(5'd0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        push_idle(); step();

        // Reverse shift of 7
        run_op(5'd7, 1'b1, 1'b0, 16'h1234, 1'b0);
        push_idle(); step();

        // Clamp 31 -> 16 with start held: back-to-back with one IDLE cycle
        run_op(5'd31, 1'b1, 1'b0, 16'hC0DE, 1'b1);
        push_idle(); step();
        run_op(5'd31, 1'b1, 1'b0, 16'h5A5A, 1'b1);
        start = 1'b0;
        push_idle(); step();

        // Start pulsed during SHIFT is ignored
        start = 1'b1; dir = 1'b0; rot = 1'b0; n_shifts = 5'd5; load_val = 16'h9F31;
        push_op(5'd5, 1'b0, 1'b0, 16'h9F31, 17);
        step();
        start = 1'b0;
        step();
        start = 1'b1; n_shifts = 5'd2; dir = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        push_idle(); step();

        // Rotate request on a full 16-bit pass
        run_op(5'd16, 1'b0, 1'b1, 16'h8001, 1'b0);
        push_idle(); step();
`ifdef REGISTRADOR_ROTATE_EN
        check("rot_word", 32'(sr), 32'h8001);
`endif

        // Reset during the third SHIFT cycle aborts without done
        start = 1'b1; dir = 1'b0; rot = 1'b0; n_shifts = 5'd8; load_val = 16'h3C3C;
        push_op(5'd8, 1'b0, 1'b0, 16'h3C3C, 3);
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        push_idle(); step();
        rst = 1'b0;
        repeat (3) begin push_idle(); step(); end

        // Reset wins over start at the same edge
        start = 1'b1; rst = 1'b1; n_shifts = 5'd2;
        push_idle(); step();
        rst = 1'b0; start = 1'b0;
        push_idle(); step();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
